// File: rtl/busca_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional single-step mode is enabled by defining BUSCA_STEP_EN.
package busca_pkg;

  localparam int         DATA_W_DEFAULT      = 8;
  localparam int         ADDR_W_DEFAULT      = 4;
  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_HALT      = 3'd3
`ifdef BUSCA_STEP_EN
    ,ST_WAIT_STEP = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/memoria_programa.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module memoria_programa #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: loads a program, fetches/issues words with a ready
// handshake, follows branches and stops on the halt opcode. BUSCA_STEP_EN adds
// a step input that gates each new fetch on a rising edge of step.
//
//   state     | meaning
//   IDLE      | after reset; program may be loaded, start begins at address 0
//   FETCH     | one cycle, registers mem[pc] into instr_out
//   ISSUE     | instr_valid held until instr_ready accepts it
//   HALT      | halt opcode accepted; program may be reloaded, start restarts
//   WAIT_STEP | (BUSCA_STEP_EN only) waits for a step edge before next fetch
module unidade_busca
  import busca_pkg::*;
#(
  parameter int         DATA_W      = DATA_W_DEFAULT,
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              instr_ready,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
`ifdef BUSCA_STEP_EN
  input  logic              step,
`endif
  output logic [DATA_W-1:0] instr_out,
  output logic [3:0]        opcode,
  output logic [3:0]        operando,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [DATA_W-1:0] instr_n;
  logic [DATA_W-1:0] mem_rdata;
  logic              valid_n;
  logic              halted_n;
  logic              mem_we;
  logic              go_next;

  memoria_programa #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

`ifdef BUSCA_STEP_EN
  // A step edge seen while still fetching/issuing is remembered, so each
  // edge releases exactly one instruction.
  logic step_q;
  logic step_pend;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= step;
      if (state == ST_IDLE || state == ST_HALT)
        step_pend <= 1'b0;
      else if (state == ST_WAIT_STEP && (step_pend || step_rise))
        step_pend <= 1'b0;
      else if (step_rise)
        step_pend <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_out   <= instr_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr_out;
    valid_n  = instr_valid;
    halted_n = halted;
    mem_we   = 1'b0;
    go_next  = 1'b0;

    case (state)
      ST_IDLE, ST_HALT: begin
        // A write always wins over start in the same cycle.
        if (load_en) begin
          mem_we = 1'b1;
        end else if (start) begin
          pc_n     = '0;
          halted_n = 1'b0;
          state_n  = ST_FETCH;
        end
      end

      ST_FETCH: begin
        instr_n = mem_rdata;
        valid_n = 1'b1;
        state_n = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          valid_n = 1'b0;
          if (opcode == HALT_OPCODE) begin
            halted_n = 1'b1;
            state_n  = ST_HALT;
          end else begin
            go_next = 1'b1;
            pc_n    = jmp_en ? jmp_addr : pc + ADDR_W'(1);
          end
        end
      end

`ifdef BUSCA_STEP_EN
      ST_WAIT_STEP: begin
        if (step_pend || step_rise) state_n = ST_FETCH;
      end
`endif

      default: state_n = ST_IDLE;
    endcase

    if (go_next) begin
`ifdef BUSCA_STEP_EN
      state_n = ST_WAIT_STEP;
`else
      state_n = ST_FETCH;
`endif
    end
  end

  assign opcode   = instr_out[7:4];
  assign operando = instr_out[3:0];

endmodule
